// File: rtl/led_blinker.sv
// ---------------------------------------------------------------------------
// led_blinker
//
// Blinks an LED a requested number of times. Each blink is ON_TICKS cycles
// lit followed by OFF_TICKS cycles dark. The dark gap after the final blink
// is kept, so two sequences issued back to back can still be told apart.
// A sequence is started by a one-cycle start strobe carrying a non-zero
// count. It can be cancelled with abort or with the asynchronous reset.
//
// Parameters
//   ON_TICKS  : cycles the LED is lit per blink       (1 .. 2^TW-1)
//   OFF_TICKS : cycles the LED is dark after a blink  (1 .. 2^TW-1)
//   CNT_W     : width of the blink-count request
//   TW        : width of the internal tick timer
//
// Ports
//   clk    in   sole clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   single-cycle request strobe
//   count  in   number of blinks, sampled only when start is accepted
//   abort  in   synchronous cancel of the running sequence
//   led    out  registered LED drive, 1 = lit
//   busy   out  registered, high while a sequence is in progress
//   done   out  registered one-cycle completion pulse
// ---------------------------------------------------------------------------
module led_blinker #(
    parameter int ON_TICKS  = 1000,
    parameter int OFF_TICKS = 1000,
    parameter int CNT_W     = 4,
    parameter int TW        = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic             abort,
    output logic             led,
    output logic             busy,
    output logic             done
);

    // Terminal timer values for the two timed phases.
    localparam logic [TW-1:0] ON_LAST  = TW'(ON_TICKS - 1);
    localparam logic [TW-1:0] OFF_LAST = TW'(OFF_TICKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [TW-1:0]    timer_r;
    logic [TW-1:0]    timer_s;
    logic [CNT_W-1:0] remaining_r;
    logic [CNT_W-1:0] remaining_s;
    logic             done_s;
    logic             led_r;
    logic             busy_r;
    logic             done_r;
    logic             accept_s;

    // Start acceptance: only from IDLE, only a non-zero request, and abort
    // in the same cycle wins over start.
    always_comb begin
        accept_s = 1'b0;
        if ((state_r == ST_IDLE) && start && !abort &&
            (count != {CNT_W{1'b0}})) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Next-state, next-timer and next-remaining logic.
    always_comb begin
        state_s     = state_r;
        timer_s     = timer_r;
        remaining_s = remaining_r;
        done_s      = 1'b0;

        case (state_r)
            ST_IDLE: begin
                // Abort in IDLE is a no-op; it only matters through accept_s.
                if (accept_s) begin
                    state_s     = ST_ON;
                    timer_s     = {TW{1'b0}};
                    remaining_s = count;
                end else begin
                    state_s     = ST_IDLE;
                end
            end

            ST_ON: begin
                if (abort) begin
                    state_s     = ST_IDLE;
                    timer_s     = {TW{1'b0}};
                    remaining_s = {CNT_W{1'b0}};
                end else if (timer_r == ON_LAST) begin
                    // One blink is finished once its lit phase ends; the
                    // dark phase that follows always runs in full.
                    state_s     = ST_OFF;
                    timer_s     = {TW{1'b0}};
                    remaining_s = remaining_r - CNT_W'(1);
                end else begin
                    timer_s     = timer_r + TW'(1);
                end
            end

            ST_OFF: begin
                if (abort) begin
                    state_s     = ST_IDLE;
                    timer_s     = {TW{1'b0}};
                    remaining_s = {CNT_W{1'b0}};
                end else if (timer_r == OFF_LAST) begin
                    timer_s = {TW{1'b0}};
                    if (remaining_r != {CNT_W{1'b0}}) begin
                        state_s = ST_ON;
                    end else begin
                        state_s = ST_IDLE;
                        done_s  = 1'b1;
                    end
                end else begin
                    timer_s = timer_r + TW'(1);
                end
            end

            default: begin
                // Unreachable encoding: recover to a clean idle.
                state_s     = ST_IDLE;
                timer_s     = {TW{1'b0}};
                remaining_s = {CNT_W{1'b0}};
                done_s      = 1'b0;
            end
        endcase
    end

    // State and counter registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            timer_r     <= {TW{1'b0}};
            remaining_r <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_s;
            timer_r     <= timer_s;
            remaining_r <= remaining_s;
        end
    end

    // Output registers, decoded from the next state so they line up
    // cycle-for-cycle with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_r  <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            led_r  <= (state_s == ST_ON);
            busy_r <= (state_s != ST_IDLE);
            done_r <= done_s;
        end
    end

    assign led  = led_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_led_blinker.sv
module tb_led_blinker;

    localparam int ON_T  = 3;
    localparam int OFF_T = 2;
    localparam int CW    = 4;
    localparam int TWID  = 8;
    localparam int PER   = ON_T + OFF_T;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [CW-1:0] count = '0;
    logic          led;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a sequence is described by the first busy cycle and
    // its length; outputs are derived arithmetically from the cycle number.
    int cyc     = 0;
    bit m_valid = 1'b0;
    int m_t0    = 0;
    int m_len   = 0;

    always #5 clk = ~clk;

    led_blinker #(
        .ON_TICKS (ON_T),
        .OFF_TICKS(OFF_T),
        .CNT_W    (CW),
        .TW       (TWID)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .count(count),
        .abort(abort),
        .led  (led),
        .busy (busy),
        .done (done)
    );

    function automatic bit m_busy(input int c);
        return m_valid && (c >= m_t0) && (c < m_t0 + m_len);
    endfunction

    function automatic bit m_led(input int c);
        return m_busy(c) && (((c - m_t0) % PER) < ON_T);
    endfunction

    function automatic bit m_done(input int c);
        return m_valid && (c == m_t0 + m_len);
    endfunction

    function automatic logic [2:0] m_out(input int c);
        return {m_led(c), m_busy(c), m_done(c)};
    endfunction

    // Apply inputs across one rising edge, advance the model, return at
    // the following falling edge where outputs are sampled.
    task automatic tick(input bit s, input logic [CW-1:0] c, input bit a);
        bit b_old;
        start = s;
        count = c;
        abort = a;
        @(posedge clk);
        b_old = m_busy(cyc);
        if (rst_n) begin
            if (b_old && a) begin
                m_valid = 1'b0;
            end else if (!b_old && s && (c != 0) && !a) begin
                m_valid = 1'b1;
                m_t0    = cyc + 1;
                m_len   = int'(c) * PER;
            end
        end else begin
            m_valid = 1'b0;
        end
        cyc++;
        #1;
        start = 1'b0;
        abort = 1'b0;
        count = '0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({led, busy, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_async got=%b exp=000", {led, busy, done});
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 4'd2, 1'b0);
            n_checks++;
            if ({led, busy, done} !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_hold cyc=%0d got=%b exp=000", cyc, {led, busy, done});
            end
        end
        rst_n = 1'b1;
        m_valid = 1'b0;
    endtask

    task automatic test_basic();
        int busy_cnt;
        int done_at;
        int t0;
        busy_cnt = 0;
        done_at  = -1;
        t0 = cyc;
        tick(1'b1, 4'd2, 1'b0);
        for (int i = 1; i <= 14; i++) begin
            n_checks++;
            if ({led, busy, done} !== m_out(cyc)) begin
                n_fail++;
                $display("FAIL basic cyc=%0d got=%b exp=%b", i, {led, busy, done}, m_out(cyc));
            end
            if (busy) busy_cnt++;
            if (done) done_at = cyc - t0;
            tick(1'b0, 4'd0, 1'b0);
        end
        n_checks++;
        if (busy_cnt != 2 * PER) begin
            n_fail++;
            $display("FAIL basic_busy_len got=%0d exp=%0d", busy_cnt, 2 * PER);
        end
        n_checks++;
        if (done_at != 11) begin
            n_fail++;
            $display("FAIL basic_done_cycle got=%0d exp=11", done_at);
        end
    endtask

    task automatic test_zero();
        tick(1'b1, 4'd0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if ({led, busy, done} !== 3'b000) begin
                n_fail++;
                $display("FAIL zero_count i=%0d got=%b exp=000", i, {led, busy, done});
            end
            tick(1'b0, 4'd0, 1'b0);
        end
    endtask

    task automatic test_busy_ignore();
        int blinks;
        int dones;
        int done_at;
        int t0;
        logic led_prev;
        blinks = 0;
        dones = 0;
        done_at = -1;
        led_prev = 1'b0;
        t0 = cyc;
        tick(1'b1, 4'd3, 1'b0);
        for (int i = 1; i <= 22; i++) begin
            n_checks++;
            if ({led, busy, done} !== m_out(cyc)) begin
                n_fail++;
                $display("FAIL busy_ignore cyc=%0d got=%b exp=%b", i, {led, busy, done}, m_out(cyc));
            end
            if (led && !led_prev) blinks++;
            led_prev = led;
            if (done) begin
                dones++;
                done_at = cyc - t0;
            end
            tick(i == 3, 4'd5, 1'b0);
        end
        n_checks++;
        if (blinks != 3 || dones != 1 || done_at != 16) begin
            n_fail++;
            $display("FAIL busy_ignore_totals got=%0d/%0d/%0d exp=3/1/16", blinks, dones, done_at);
        end
    endtask

    task automatic test_abort();
        tick(1'b1, 4'd2, 1'b0);
        for (int i = 1; i <= 26; i++) begin
            n_checks++;
            if ({led, busy, done} !== m_out(cyc)) begin
                n_fail++;
                $display("FAIL abort cyc=%0d got=%b exp=%b", i, {led, busy, done}, m_out(cyc));
            end
            if (i >= 6 && {led, busy, done} !== 3'b000) begin
                n_fail++;
                $display("FAIL abort_quiet cyc=%0d got=%b exp=000", i, {led, busy, done});
            end
            tick(1'b0, 4'd0, i == 5);
        end
        // Abort together with start in IDLE: start is dropped.
        tick(1'b1, 4'd3, 1'b1);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({led, busy, done} !== 3'b000) begin
                n_fail++;
                $display("FAIL abort_start i=%0d got=%b exp=000", i, {led, busy, done});
            end
            tick(1'b0, 4'd0, 1'b1);
        end
    endtask

    task automatic test_back_to_back();
        int first_done;
        int second_done;
        first_done = -1;
        second_done = -1;
        tick(1'b1, 4'd2, 1'b0);
        for (int i = 0; i < 30 && first_done < 0; i++) begin
            if (done) first_done = cyc;
            else tick(1'b0, 4'd0, 1'b0);
        end
        n_checks++;
        if (first_done < 0 || !m_done(cyc)) begin
            n_fail++;
            $display("FAIL b2b_first_done got=%0d exp=done seen", first_done);
        end
        tick(1'b1, 4'd1, 1'b0);
        n_checks++;
        if (led !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_restart got=%b%b exp=11", led, busy);
        end
        for (int i = 0; i < 10 && second_done < 0; i++) begin
            n_checks++;
            if ({led, busy, done} !== m_out(cyc)) begin
                n_fail++;
                $display("FAIL b2b cyc=%0d got=%b exp=%b", cyc, {led, busy, done}, m_out(cyc));
            end
            if (done) second_done = cyc;
            else tick(1'b0, 4'd0, 1'b0);
        end
        n_checks++;
        if (second_done - first_done != PER + 1) begin
            n_fail++;
            $display("FAIL b2b_spacing got=%0d exp=%0d", second_done - first_done, PER + 1);
        end
        tick(1'b0, 4'd0, 1'b0);
    endtask

    task automatic test_async_reset();
        int busy_cnt;
        int blinks;
        int dones;
        logic led_prev;
        busy_cnt = 0;
        blinks = 0;
        dones = 0;
        led_prev = 1'b0;
        tick(1'b1, 4'd2, 1'b0);
        tick(1'b0, 4'd0, 1'b0);
        // Mid-ON, pulse reset away from any clock edge.
        #2 rst_n = 1'b0;
        m_valid = 1'b0;
        #1;
        n_checks++;
        if ({led, busy, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL async_reset got=%b exp=000", {led, busy, done});
        end
        rst_n = 1'b1;
        tick(1'b1, 4'd15, 1'b0);
        for (int i = 0; i < 80; i++) begin
            n_checks++;
            if ({led, busy, done} !== m_out(cyc)) begin
                n_fail++;
                $display("FAIL max_count cyc=%0d got=%b exp=%b", cyc, {led, busy, done}, m_out(cyc));
            end
            if (busy) busy_cnt++;
            if (done) dones++;
            if (led && !led_prev) blinks++;
            led_prev = led;
            tick(1'b0, 4'd0, 1'b0);
        end
        n_checks++;
        if (busy_cnt != 15 * PER || blinks != 15 || dones != 1) begin
            n_fail++;
            $display("FAIL max_count_totals got=%0d/%0d/%0d exp=%0d/15/1", busy_cnt, blinks, dones, 15 * PER);
        end
    endtask

    task automatic test_random();
        bit s;
        bit a;
        logic [CW-1:0] c;
        for (int i = 0; i < 600; i++) begin
            s = ($urandom_range(0, 3) == 0);
            a = ($urandom_range(0, 29) == 0);
            c = CW'($urandom_range(0, 6));
            tick(s, c, a);
            n_checks++;
            if ({led, busy, done} !== m_out(cyc)) begin
                n_fail++;
                $display("FAIL random cyc=%0d got=%b exp=%b", cyc, {led, busy, done}, m_out(cyc));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_busy_ignore();
        test_abort();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
